je_read_sched: RTL and testbench
================================

JE_READ_SCHED -- requirements
Module: je_read_sched

Interface
REQ-001 Parameter BLOCK_BYTES, default 192, bytes per block burst (3 planes x 8 x 8).
REQ-002 Parameter NUM_BLOCKS, default 1200, blocks per image (320x240 / 64).
REQ-003 Parameter REQ_CYCLES, default 50, img_req high time in clocks.
REQ-004 Parameter GAP_CYCLES, default 16, minimum idle clocks between bursts.
REQ-005 Parameter TIMEOUT_CYCLES, default 4096, je_ready wait limit (used only with JE_SCHED_TIMEOUT_EN).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  frame request pulse from host.
REQ-009 abort  input  1  synchronous frame cancel.
REQ-010 je_ready  input  1  encoder ready to accept one block.
REQ-011 img_req  output  1  image request to yuyv_to_yuv converter.
REQ-012 je_rd  output  1  block read strobe to converter, one byte per cycle.
REQ-013 blk_idx  output  11  index of current/next block, 0..NUM_BLOCKS-1.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 done  output  1  one-cycle pulse at frame completion.
REQ-016 err  output  1  one-cycle pulse on timeout (tied 0 when the timeout feature is compiled out).

Function
REQ-017 States SHALL be IDLE, REQ, WAIT_RDY, BURST, GAP, DONE.
REQ-018 IDLE->REQ on start=1; start SHALL be ignored in every other state.
REQ-019 REQ: img_req SHALL be high for exactly REQ_CYCLES cycles, starting the cycle after start is sampled; then WAIT_RDY.
REQ-020 WAIT_RDY->BURST on je_ready=1; je_rd SHALL rise the cycle after je_ready is sampled high.
REQ-021 BURST: je_rd SHALL be high for exactly BLOCK_BYTES consecutive cycles; je_ready SHALL be ignored during BURST.
REQ-022 End of burst: if blk_idx==NUM_BLOCKS-1 -> DONE, else blk_idx+1 -> GAP.
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles, then WAIT_RDY; je_ready held high during GAP SHALL NOT shorten the gap.
REQ-024 DONE SHALL last one cycle with done=1, clear blk_idx to 0, then IDLE.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE next cycle: img_req, je_rd low; blk_idx 0; no done pulse.
REQ-026 abort and start asserted together in IDLE: abort SHALL win, state remains IDLE.
REQ-027 Byte counter 8 bits, block counter 11 bits; neither counter SHALL wrap: both are reloaded or cleared by the state machine only.
REQ-028 All outputs SHALL be registered (no combinational path from inputs to outputs).

Reset
REQ-029 On reset_n=0: state IDLE; img_req, je_rd, busy, done, err = 0; blk_idx = 0; all counters = 0.
REQ-030 Reset mid-burst SHALL drop je_rd immediately (asynchronously); no partial-block resume after reset release.

Configuration
REQ-031 With JE_SCHED_TIMEOUT_EN defined: WAIT_RDY lasting TIMEOUT_CYCLES cycles without je_ready SHALL pulse err for one cycle and go to IDLE with blk_idx = 0.
REQ-032 Without JE_SCHED_TIMEOUT_EN: WAIT_RDY waits indefinitely; err tied 0; no timeout counter is synthesized.

Structure
REQ-033 Package je_sched_pkg SHALL hold the state enum typedef and the default constants BLOCK_BYTES, NUM_BLOCKS, REQ_CYCLES and GAP_CYCLES.
REQ-034 One sub-module sched_down_counter (loadable down-counter with zero flag) SHALL be instantiated for the REQ, BURST and GAP timing.

Verification
REQ-035 NUM_BLOCKS=3, je_ready tied 1: start -> img_req 50 cycles, three je_rd bursts of 192 cycles separated by 16-cycle gaps, done pulse once, blk_idx 0,1,2 then 0.
REQ-036 je_ready delayed 100 cycles after each gap -> je_rd rises exactly 1 cycle after je_ready is sampled high; burst length remains 192.
REQ-037 abort at cycle 50 of the second burst -> je_rd low next cycle, busy 0, no done, blk_idx 0; a following start runs a full frame.
REQ-038 start pulses during BURST and GAP -> no effect; block count and done timing are unchanged.
REQ-039 JE_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=64, je_ready held 0 -> err pulse 64 cycles after entering WAIT_RDY, then IDLE; without the macro, busy stays 1.
REQ-040 reset_n low for 3 cycles mid-burst -> all outputs 0 immediately; after release, state IDLE until start.

Source files
------------

// File: rtl/je_sched_pkg.sv
// State encoding and default timing constants for the JPEG-encoder block read scheduler.
package je_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RDY,
    S_BURST,
    S_GAP,
    S_DONE
  } sched_state_e;

  localparam int BLOCK_BYTES_DFLT    = 192;   // 3 planes x 8 x 8
  localparam int NUM_BLOCKS_DFLT     = 1200;  // 320x240 / 64
  localparam int REQ_CYCLES_DFLT     = 50;
  localparam int GAP_CYCLES_DFLT     = 16;
  localparam int TIMEOUT_CYCLES_DFLT = 4096;

endpackage

// File: rtl/sched_down_counter.sv
// Loadable down-counter with zero flag; load wins over decrement and the count holds at zero.
module sched_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/je_read_sched.sv
// Frame read scheduler: image request, then one byte-per-cycle burst per block with gaps between blocks.
// All outputs registered; `define JE_SCHED_TIMEOUT_EN adds a je_ready wait timeout that pulses err.
module je_read_sched
  import je_sched_pkg::*;
#(
  parameter int BLOCK_BYTES    = BLOCK_BYTES_DFLT,
  parameter int NUM_BLOCKS     = NUM_BLOCKS_DFLT,
  parameter int REQ_CYCLES     = REQ_CYCLES_DFLT,
  parameter int GAP_CYCLES     = GAP_CYCLES_DFLT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        je_ready,
  output logic        img_req,
  output logic        je_rd,
  output logic [10:0] blk_idx,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // The shared 8-bit phase counter and 11-bit block index bound the legal ranges.
  if (BLOCK_BYTES < 1 || BLOCK_BYTES > 256 || REQ_CYCLES < 1 || REQ_CYCLES > 256 ||
      GAP_CYCLES < 1 || GAP_CYCLES > 256 || NUM_BLOCKS < 1 || NUM_BLOCKS > 2048 ||
      TIMEOUT_CYCLES < 1) begin : g_param_range
    $error("je_read_sched: parameter out of range");
  end

  sched_state_e state, state_nxt;
  logic [10:0]  blk_nxt;
  logic         blk_last;
  logic         cnt_zero;
  logic         cnt_load;
  logic         cnt_dec;
  logic [7:0]   cnt_val;
  logic         timeout;

  assign blk_last = (blk_idx == 11'(NUM_BLOCKS - 1));

  always_comb begin
    state_nxt = state;
    blk_nxt   = blk_idx;
    if (abort) begin
      state_nxt = S_IDLE;
      blk_nxt   = '0;
    end else begin
      unique case (state)
        S_IDLE:     if (start) state_nxt = S_REQ;
        S_REQ:      if (cnt_zero) state_nxt = S_WAIT_RDY;
        S_WAIT_RDY: begin
          if (je_ready) begin
            state_nxt = S_BURST;
          end else if (timeout) begin
            state_nxt = S_IDLE;
            blk_nxt   = '0;
          end
        end
        S_BURST: begin
          if (cnt_zero) begin
            if (blk_last) begin
              state_nxt = S_DONE;
              blk_nxt   = '0;
            end else begin
              state_nxt = S_GAP;
              blk_nxt   = blk_idx + 11'd1;
            end
          end
        end
        S_GAP:      if (cnt_zero) state_nxt = S_WAIT_RDY;
        S_DONE:     state_nxt = S_IDLE;
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  // Each timed phase reloads the counter with length-1 on entry and exits when it reads zero.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (state_nxt != state) begin
      unique case (state_nxt)
        S_REQ:   begin cnt_load = 1'b1; cnt_val = 8'(REQ_CYCLES - 1);  end
        S_BURST: begin cnt_load = 1'b1; cnt_val = 8'(BLOCK_BYTES - 1); end
        S_GAP:   begin cnt_load = 1'b1; cnt_val = 8'(GAP_CYCLES - 1);  end
        default: cnt_load = 1'b0;
      endcase
    end
  end

  assign cnt_dec = (state == S_REQ) || (state == S_BURST) || (state == S_GAP);

  sched_down_counter #(.W(8)) u_phase_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      blk_idx <= '0;
      img_req <= 1'b0;
      je_rd   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      blk_idx <= blk_nxt;
      img_req <= (state_nxt == S_REQ);
      je_rd   <= (state_nxt == S_BURST);
      busy    <= (state_nxt != S_IDLE);
      done    <= (state_nxt == S_DONE);
    end
  end

`ifdef JE_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  assign timeout = (state == S_WAIT_RDY) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Restarts on every entry to WAIT_RDY, so each block gets the full wait budget.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err <= timeout && !je_ready && !abort;
      if (state != S_WAIT_RDY) begin
        to_cnt <= '0;
      end else if (!timeout) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_je_read_sched.sv
// Scenario bench for je_read_sched: per-cycle output traces compared against a phase-level frame model.
module tb_je_read_sched;

  localparam int BB    = 192;
  localparam int NBLK  = 3;
  localparam int REQ_C = 50;
  localparam int GAP_C = 16;
  localparam int TO_C  = 64;
  localparam int MAXW  = 4096;
`ifdef JE_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam int LONG_DLY = 60;
`else
  localparam bit TO_EN = 1'b0;
  localparam int LONG_DLY = 100;
`endif
  // Cycles from the start cycle to the done pulse when je_ready is held high.
  localparam int DONE_OFS = 1 + REQ_C + NBLK * (1 + BB) + (NBLK - 1) * GAP_C;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort, je_ready;
  logic        img_req, je_rd, busy, done, err;
  logic [10:0] blk_idx;

  int errors = 0;
  int checks = 0;

  // Trace word: {img_req, je_rd, busy, done, err, blk_idx}
  logic [15:0] obs_w [MAXW];
  logic [15:0] exp_w [MAXW];
  bit stim_start [MAXW];
  bit stim_abort [MAXW];
  bit stim_ready [MAXW];

  always #5 clk = ~clk;

  je_read_sched #(
    .BLOCK_BYTES(BB), .NUM_BLOCKS(NBLK), .REQ_CYCLES(REQ_C),
    .GAP_CYCLES(GAP_C), .TIMEOUT_CYCLES(TO_C)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .je_ready(je_ready),
    .img_req(img_req), .je_rd(je_rd), .blk_idx(blk_idx), .busy(busy), .done(done), .err(err)
  );

  task automatic clear_stim();
    for (int c = 0; c < MAXW; c++) begin
      stim_start[c] = 0; stim_abort[c] = 0; stim_ready[c] = 0;
    end
  endtask

  // Record outputs at each falling edge, then apply that cycle's inputs.
  task automatic run_window(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      obs_w[c]  = {img_req, je_rd, busy, done, err, blk_idx};
      start     = stim_start[c];
      abort     = stim_abort[c];
      je_ready  = stim_ready[c];
    end
    @(negedge clk);
    start = 0; abort = 0; je_ready = 0;
  endtask

  function automatic void put(input int t, input bit img, input bit rd, input bit dn, input int blk);
    if (t < MAXW) exp_w[t] = {img, rd, 1'b1, dn, 1'b0, 11'(blk)};
  endfunction

  // Frame model walked phase by phase: request, then per block wait/burst/gap, then done.
  task automatic build_expect(input int n);
    int t, w;
    bit gone;
    for (int c = 0; c < MAXW; c++) exp_w[c] = '0;
    t = 0;
    while (t < n) begin
      if (!stim_start[t] || stim_abort[t]) begin
        t++;
        continue;
      end
      t++;
      gone = 0;
      for (int k = 0; k < REQ_C && !gone && t < n; k++) begin
        put(t, 1, 0, 0, 0); gone = stim_abort[t]; t++;
      end
      for (int b = 0; b < NBLK && !gone && t < n; b++) begin
        w = 0;
        while (!gone && t < n) begin
          put(t, 0, 0, 0, b);
          if (stim_abort[t]) begin
            gone = 1; t++;
          end else if (stim_ready[t]) begin
            t++;
            break;
          end else if (TO_EN && w == TO_C - 1) begin
            t++;
            if (t < MAXW) exp_w[t][11] = 1'b1;
            gone = 1;
          end else begin
            w++; t++;
          end
        end
        for (int k = 0; k < BB && !gone && t < n; k++) begin
          put(t, 0, 1, 0, b); gone = stim_abort[t]; t++;
        end
        if (gone || t >= n) break;
        if (b == NBLK - 1) begin
          put(t, 0, 0, 1, 0); t++;
        end else begin
          for (int k = 0; k < GAP_C && !gone && t < n; k++) begin
            put(t, 0, 0, 0, b + 1); gone = stim_abort[t]; t++;
          end
        end
      end
    end
  endtask

  function automatic int first_high(input int n, input int pos);
    for (int c = 0; c < n; c++) if (obs_w[c][pos]) return c;
    return -1;
  endfunction

  function automatic int count_rises(input int n, input int pos);
    int r = 0;
    for (int c = 0; c < n; c++) if (obs_w[c][pos] && (c == 0 || !obs_w[c-1][pos])) r++;
    return r;
  endfunction

  task automatic test_reset();
    reset_n = 0; start = 0; abort = 0; je_ready = 0;
    #12;
    checks += 6;
    if (img_req !== 1'b0) begin errors++; $display("FAIL reset_img_req got %b want 0", img_req); end
    if (je_rd !== 1'b0)   begin errors++; $display("FAIL reset_je_rd got %b want 0", je_rd); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
    if (err !== 1'b0)     begin errors++; $display("FAIL reset_err got %b want 0", err); end
    if (blk_idx !== 11'd0) begin errors++; $display("FAIL reset_blk_idx got %0d want 0", blk_idx); end
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_frame();
    int n = 720, mism = -1, d;
    clear_stim();
    stim_start[2] = 1;
    for (int c = 0; c < n; c++) stim_ready[c] = 1;
    build_expect(n);
    run_window(n);
    for (int c = 0; c < n; c++) if (mism < 0 && obs_w[c] !== exp_w[c]) mism = c;
    checks++;
    if (mism >= 0) begin errors++; $display("FAIL frame_trace cycle %0d got %h want %h", mism, obs_w[mism], exp_w[mism]); end
    d = first_high(n, 12);
    checks++;
    if (d != 2 + DONE_OFS) begin errors++; $display("FAIL frame_done_cycle got %0d want %0d", d, 2 + DONE_OFS); end
    d = count_rises(n, 12);
    checks++;
    if (d != 1) begin errors++; $display("FAIL frame_done_count got %0d want 1", d); end
    d = count_rises(n, 14);
    checks++;
    if (d != NBLK) begin errors++; $display("FAIL frame_burst_count got %0d want %0d", d, NBLK); end
    d = 0;
    for (int c = 0; c < n; c++) d += int'(obs_w[c][15]);
    checks++;
    if (d != REQ_C) begin errors++; $display("FAIL frame_img_req_len got %0d want %0d", d, REQ_C); end
  endtask

  task automatic test_ready_delay();
    int n = 1300, mism = -1, bad = 0, d;
    clear_stim();
    stim_start[2] = 1;
    for (int c = 0; c < n; c++) stim_ready[c] = ((c % (LONG_DLY + 1)) == LONG_DLY);
    build_expect(n);
    run_window(n);
    for (int c = 0; c < n; c++) if (mism < 0 && obs_w[c] !== exp_w[c]) mism = c;
    checks++;
    if (mism >= 0) begin errors++; $display("FAIL delay_trace cycle %0d got %h want %h", mism, obs_w[mism], exp_w[mism]); end
    for (int c = 1; c < n; c++) if (obs_w[c][14] && !obs_w[c-1][14] && !stim_ready[c-1]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL delay_rd_after_ready got %0d bad rises want 0", bad); end
    d = 0;
    for (int c = 0; c < n; c++) d += int'(obs_w[c][14]);
    checks++;
    if (d != NBLK * BB) begin errors++; $display("FAIL delay_rd_total got %0d want %0d", d, NBLK * BB); end
  endtask

  task automatic test_start_ignored();
    int n = 720, mism = -1, d;
    clear_stim();
    stim_start[2] = 1;
    for (int c = 0; c < n; c++) stim_ready[c] = 1;
    stim_start[100] = 1;   // first burst
    stim_start[250] = 1;   // first gap
    stim_start[400] = 1;   // second burst
    stim_start[460] = 1;   // second gap
    build_expect(n);
    run_window(n);
    for (int c = 0; c < n; c++) if (mism < 0 && obs_w[c] !== exp_w[c]) mism = c;
    checks++;
    if (mism >= 0) begin errors++; $display("FAIL ignore_trace cycle %0d got %h want %h", mism, obs_w[mism], exp_w[mism]); end
    d = first_high(n, 12);
    checks++;
    if (d != 2 + DONE_OFS) begin errors++; $display("FAIL ignore_done_cycle got %0d want %0d", d, 2 + DONE_OFS); end
    d = count_rises(n, 12);
    checks++;
    if (d != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", d); end
  endtask

  task automatic test_abort();
    int a = 2 + 1 + REQ_C + 1 + BB + GAP_C + 1 + 49;
    int r = a + 10;
    int n = r + 720, mism = -1, d;
    clear_stim();
    stim_start[2] = 1;
    for (int c = 0; c < n; c++) stim_ready[c] = 1;
    stim_abort[a] = 1;
    stim_start[r] = 1;
    build_expect(n);
    run_window(n);
    for (int c = 0; c < n; c++) if (mism < 0 && obs_w[c] !== exp_w[c]) mism = c;
    checks++;
    if (mism >= 0) begin errors++; $display("FAIL abort_trace cycle %0d got %h want %h", mism, obs_w[mism], exp_w[mism]); end
    checks += 4;
    if (obs_w[a][14] !== 1'b1) begin errors++; $display("FAIL abort_in_burst je_rd got %b want 1", obs_w[a][14]); end
    if (obs_w[a+1][14] !== 1'b0) begin errors++; $display("FAIL abort_je_rd got %b want 0", obs_w[a+1][14]); end
    if (obs_w[a+1][13] !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", obs_w[a+1][13]); end
    if (obs_w[a+1][10:0] !== 11'd0) begin errors++; $display("FAIL abort_blk_idx got %0d want 0", obs_w[a+1][10:0]); end
    d = first_high(n, 12);
    checks++;
    if (d != r + DONE_OFS) begin errors++; $display("FAIL abort_restart_done got %0d want %0d", d, r + DONE_OFS); end
  endtask

  task automatic test_timeout();
    int n = 2 + 1 + REQ_C + TO_C + 40, mism = -1, d;
    clear_stim();
    stim_start[2] = 1;
    stim_abort[n-5] = 1;
    build_expect(n);
    run_window(n);
    for (int c = 0; c < n; c++) if (mism < 0 && obs_w[c] !== exp_w[c]) mism = c;
    checks++;
    if (mism >= 0) begin errors++; $display("FAIL timeout_trace cycle %0d got %h want %h", mism, obs_w[mism], exp_w[mism]); end
`ifdef JE_SCHED_TIMEOUT_EN
    d = first_high(n, 11);
    checks++;
    if (d != 2 + 1 + REQ_C + TO_C) begin errors++; $display("FAIL timeout_err_cycle got %0d want %0d", d, 2 + 1 + REQ_C + TO_C); end
`else
    d = int'(obs_w[n-6][13]);
    checks++;
    if (d != 1) begin errors++; $display("FAIL timeout_busy_held got %0d want 1", d); end
`endif
  endtask

  task automatic test_random();
    int n = 2500, mism = -1, got = 0, want = 0;
    clear_stim();
    stim_start[2] = 1;
    for (int c = 3; c < n - 40; c++) begin
      stim_start[c] = ($urandom_range(0, 39) == 0);
      stim_abort[c] = ($urandom_range(0, 799) == 0);
    end
    for (int c = 0; c < n; c++) stim_ready[c] = ($urandom_range(0, 2) == 0);
    stim_abort[n-3] = 1;
    build_expect(n);
    run_window(n);
    for (int c = 0; c < n; c++) if (mism < 0 && obs_w[c] !== exp_w[c]) mism = c;
    checks++;
    if (mism >= 0) begin errors++; $display("FAIL random_trace cycle %0d got %h want %h", mism, obs_w[mism], exp_w[mism]); end
    for (int c = 0; c < n; c++) begin
      got  += int'(obs_w[c][12]);
      want += int'(exp_w[c][12]);
    end
    checks++;
    if (got != want) begin errors++; $display("FAIL random_done_count got %0d want %0d", got, want); end
  endtask

  task automatic test_reset_mid_burst();
    int mism = -1;
    clear_stim();
    stim_start[2] = 1;
    for (int c = 0; c < MAXW; c++) stim_ready[c] = 1;
    build_expect(150);
    run_window(150);
    for (int c = 0; c < 150; c++) if (mism < 0 && obs_w[c] !== exp_w[c]) mism = c;
    checks++;
    if (mism >= 0) begin errors++; $display("FAIL midrst_pre_trace cycle %0d got %h want %h", mism, obs_w[mism], exp_w[mism]); end
    checks++;
    if (je_rd !== 1'b1) begin errors++; $display("FAIL midrst_in_burst je_rd got %b want 1", je_rd); end
    #2 reset_n = 0;
    #1;
    checks += 3;
    if (je_rd !== 1'b0) begin errors++; $display("FAIL midrst_je_rd got %b want 0", je_rd); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    if (blk_idx !== 11'd0) begin errors++; $display("FAIL midrst_blk_idx got %0d want 0", blk_idx); end
    repeat (3) @(negedge clk);
    reset_n = 1;
    clear_stim();
    for (int c = 0; c < MAXW; c++) stim_ready[c] = 1;
    build_expect(100);
    run_window(100);
    mism = -1;
    for (int c = 0; c < 100; c++) if (mism < 0 && obs_w[c] !== exp_w[c]) mism = c;
    checks++;
    if (mism >= 0) begin errors++; $display("FAIL midrst_idle_trace cycle %0d got %h want %h", mism, obs_w[mism], exp_w[mism]); end
    stim_start[5] = 1;
    build_expect(720);
    run_window(720);
    mism = -1;
    for (int c = 0; c < 720; c++) if (mism < 0 && obs_w[c] !== exp_w[c]) mism = c;
    checks++;
    if (mism >= 0) begin errors++; $display("FAIL midrst_frame_trace cycle %0d got %h want %h", mism, obs_w[mism], exp_w[mism]); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame();
    test_ready_delay();
    test_start_ignored();
    test_abort();
    test_timeout();
    test_random();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
